pmem_line_responder: RTL and testbench

//  Responder end of the cache-to-physical-memory line protocol (pmem_read/pmem_write/pmem_resp).

---
 rtl/lc3b_types.sv | 27 ++
 rtl/pmem_line_array.sv | 28 ++
 rtl/pmem_line_responder.sv | 121 ++++++++++++
 tb/tb_pmem_line_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared types for the cache-to-physical-memory line protocol.
// Word/line typedefs, op and FSM encodings, counter sizing helper.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic {
    PMEM_RD,
    PMEM_WR
  } pmem_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP,
    S_RECOVER
  } pmem_state_t;

  // Width able to hold max(a,b)-1 as a down-counter preload
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pmem_line_array.sv
// Single-port line storage: synchronous write, registered read.
// Contents survive reset by design.
module pmem_line_array
  import lc3b_types::*;
#(
  parameter int INDEX_BITS = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [INDEX_BITS-1:0] i_idx,
  input  lc3b_line              i_wdata,
  output lc3b_line              o_rdata
);

  localparam int DEPTH = 2 ** INDEX_BITS;

  lc3b_line r_mem [DEPTH];
  lc3b_line r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pmem_line_responder.sv
// Line-protocol responder backed by an on-chip array.
// Completes one read/write at a time after a programmable latency.
module pmem_line_responder
  import lc3b_types::*;
#(
  parameter int INDEX_BITS    = 8,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  lc3b_word pmem_address,
  input  logic     pmem_read,
  input  logic     pmem_write,
  input  lc3b_line pmem_wdata,
  output lc3b_line pmem_rdata,
  output logic     pmem_resp,
  output logic     pmem_error
);

  localparam int CW = cnt_width(READ_LATENCY, WRITE_LATENCY);
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);
  localparam lc3b_word IDX_MASK =
    lc3b_word'(((1 << INDEX_BITS) - 1) << 4);

  pmem_state_t           r_state;
  pmem_state_t           w_next;
  logic [CW-1:0]         r_cnt;
  logic [INDEX_BITS-1:0] r_idx;
  pmem_op_t              r_op;
  lc3b_line              r_wdata;
  logic                  r_error;
  logic                  r_rd_valid;

  logic                  w_req;
  logic                  w_accept;
  pmem_op_t              w_in_op;
  logic [INDEX_BITS-1:0] w_in_idx;
  logic [CW-1:0]         w_load;
  pmem_op_t              w_cur_op;
  logic [INDEX_BITS-1:0] w_cur_idx;
  logic                  w_we;
  logic                  w_re;
  lc3b_line              w_arr_rdata;
  logic                  w_unused;

  assign w_req    = pmem_read | pmem_write;
  assign w_accept = (r_state == S_IDLE) && w_req;
  assign w_in_op  = pmem_write ? PMEM_WR : PMEM_RD;
  assign w_in_idx = pmem_address[INDEX_BITS+3:4];
  assign w_load   = (w_in_op == PMEM_WR) ? WR_LOAD : RD_LOAD;
  assign w_unused = ^(pmem_address & ~IDX_MASK);

  // With LAT==1 the array is addressed straight from the request
  assign w_cur_op  = (r_state == S_IDLE) ? w_in_op : r_op;
  assign w_cur_idx = (r_state == S_IDLE) ? w_in_idx : r_idx;

  assign w_re = (w_next == S_RESP) && (w_cur_op == PMEM_RD);
  assign w_we = (r_state == S_RESP) && (r_op == PMEM_WR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) w_next = (w_load == '0) ? S_RESP : S_BUSY;
      end
      S_BUSY: begin
        if (r_cnt <= CW'(1)) w_next = S_RESP;
      end
      S_RESP:    w_next = S_RECOVER;
      S_RECOVER: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    pmem_resp  = (r_state == S_RESP);
    pmem_error = r_error;
    pmem_rdata = r_rd_valid ? w_arr_rdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_op       <= PMEM_RD;
      r_wdata    <= '0;
      r_error    <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= w_load;
        r_idx   <= w_in_idx;
        r_op    <= w_in_op;
        r_wdata <= pmem_wdata;
        if (pmem_read && pmem_write) r_error <= 1'b1;
      end else if (r_state == S_BUSY && r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_re) r_rd_valid <= 1'b1;
    end
  end

  pmem_line_array #(
    .INDEX_BITS(INDEX_BITS)
  ) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_re   (w_re),
    .i_idx  (w_cur_idx),
    .i_wdata(r_wdata),
    .o_rdata(w_arr_rdata)
  );

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench for pmem_line_responder.
// Checks latency, data, aliasing, overlap, error flag and reset abort.
module tb_pmem_line_responder;
  import lc3b_types::*;

  logic     clk = 1'b0;
  logic     rst;
  lc3b_word pmem_address;
  logic     pmem_read;
  logic     pmem_write;
  lc3b_line pmem_wdata;
  lc3b_line pmem_rdata;
  logic     pmem_resp;
  logic     pmem_error;

  int n_tests  = 0;
  int n_failed = 0;
  int resp_cnt = 0;

  localparam lc3b_line P_LINE = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam lc3b_line D_LINE = 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF;
  localparam lc3b_line W_LINE = 128'hCAFE_0123_4567_89AB_CDEF_FEDC_BA98_7654;
  localparam lc3b_line E_LINE = 128'h5A5A_A5A5_0F0F_F0F0_1234_5678_9ABC_DEF0;
  localparam lc3b_line A_LINE = 128'h0000_0000_0000_0000_0000_0000_0000_00A1;
  localparam lc3b_line B_LINE = 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB;

  pmem_line_responder dut (
    .clk         (clk),
    .rst         (rst),
    .pmem_address(pmem_address),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp),
    .pmem_error  (pmem_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pmem_resp === 1'b1) resp_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one request in an IDLE cycle; lat = cycles accept->resp
  task automatic xact(input logic rd, input logic wr,
                      input lc3b_word a, input lc3b_line wd,
                      input bit hold, output int lat,
                      output lc3b_line rdo);
    int n;
    bit got;
    @(posedge clk); #1;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = a;
    pmem_wdata   = wd;
    n   = 0;
    got = 0;
    while (!got && n < 32) begin
      @(negedge clk);
      n++;
      if (pmem_resp === 1'b1) got = 1;
    end
    rdo = pmem_rdata;
    lat = got ? n - 1 : -1;
    if (hold) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  task automatic wait_cyc(input int k);
    for (int i = 0; i < k; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    int       lat;
    int       n;
    int       c0;
    bit       got;
    lc3b_line rd;

    rst          = 1'b1;
    pmem_address = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = '0;
    wait_cyc(2);
    chk("rst_resp", pmem_resp, 1'b0);
    chk("rst_rdata", pmem_rdata, '0);
    chk("rst_error", pmem_error, 1'b0);
    rst = 1'b0;

    // preload line 5, then show reset keeps contents
    xact(1'b0, 1'b1, 16'h0050, P_LINE, 1'b0, lat, rd);
    chk("preload_lat", lat, 4);
    wait_cyc(1);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    chk("rdata_after_rst", pmem_rdata, '0);

    // 1: read idx 5
    c0 = resp_cnt;
    xact(1'b1, 1'b0, 16'h0050, '0, 1'b0, lat, rd);
    wait_cyc(4);
    chk("t1_lat", lat, 4);
    chk("t1_data", rd, P_LINE);
    chk("t1_resp_cnt", resp_cnt - c0, 1);
    chk("t1_rdata_hold", pmem_rdata, P_LINE);

    // 2: low nibble ignored, upper bits alias
    xact(1'b0, 1'b1, 16'h0123, D_LINE, 1'b0, lat, rd);
    chk("t2_wlat", lat, 4);
    xact(1'b1, 1'b0, 16'h0120, '0, 1'b0, lat, rd);
    chk("t2_rlat", lat, 4);
    chk("t2_data", rd, D_LINE);
    xact(1'b1, 1'b0, 16'hF12C, '0, 1'b0, lat, rd);
    chk("t2_alias", rd, D_LINE);

    // 3: dirty evict, read raised during RECOVER
    wait_cyc(1);
    c0 = resp_cnt;
    @(posedge clk); #1;
    pmem_write   = 1'b1;
    pmem_address = 16'h0340;
    pmem_wdata   = W_LINE;
    got = 0;
    n   = 0;
    while (!got && n < 32) begin
      @(negedge clk);
      n++;
      if (pmem_resp === 1'b1) got = 1;
    end
    chk("t3_wresp_seen", got, 1'b1);
    @(posedge clk); #1;
    pmem_write = 1'b0;
    pmem_read  = 1'b1;
    got = 0;
    n   = 0;
    while (!got && n < 32) begin
      @(negedge clk);
      n++;
      if (pmem_resp === 1'b1) got = 1;
    end
    rd = pmem_rdata;
    @(posedge clk); #1;
    pmem_read = 1'b0;
    wait_cyc(6);
    chk("t3_read_cycles", got ? n : -1, 6);
    chk("t3_data", rd, W_LINE);
    chk("t3_resp_cnt", resp_cnt - c0, 2);

    // 4: read held through RECOVER
    c0 = resp_cnt;
    xact(1'b1, 1'b0, 16'h0050, '0, 1'b1, lat, rd);
    wait_cyc(8);
    chk("t4_data", rd, P_LINE);
    chk("t4_resp_cnt", resp_cnt - c0, 1);

    // 5: read+write together
    chk("t5_err_pre", pmem_error, 1'b0);
    c0 = resp_cnt;
    xact(1'b1, 1'b1, 16'h0070, E_LINE, 1'b0, lat, rd);
    wait_cyc(3);
    chk("t5_lat", lat, 4);
    chk("t5_resp_cnt", resp_cnt - c0, 1);
    chk("t5_err", pmem_error, 1'b1);
    xact(1'b1, 1'b0, 16'h0070, '0, 1'b0, lat, rd);
    chk("t5_data", rd, E_LINE);
    chk("t5_err_sticky", pmem_error, 1'b1);

    // 6: reset during BUSY of a write
    xact(1'b0, 1'b1, 16'h0200, A_LINE, 1'b0, lat, rd);
    @(posedge clk); #1;
    pmem_write   = 1'b1;
    pmem_address = 16'h0200;
    pmem_wdata   = B_LINE;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_resp_rst", pmem_resp, 1'b0);
    chk("t6_err_rst", pmem_error, 1'b0);
    pmem_write = 1'b0;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(1);
    c0 = resp_cnt;
    xact(1'b1, 1'b0, 16'h0200, '0, 1'b0, lat, rd);
    chk("t6_old_data", rd, A_LINE);
    chk("t6_lat", lat, 4);
    wait_cyc(2);
    chk("t6_resp_cnt", resp_cnt - c0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
